// File: rtl/vsplat_wb_unit.sv
// Scalar-broadcast writeback: expands one scalar into a 1- or 4-register vector group
// and streams it to the VRF one register per beat, zero-filling elements past vl.
`timescale 1ns/1ps
module vsplat_wb_unit #(
  parameter int unsigned VLEN_BITS = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 sew,
  input  logic                 lmul,
  input  logic [4:0]           vd_idx,
  input  logic [6:0]           vl,
  input  logic [31:0]          scalar_in,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [VLEN_BITS-1:0] rf_wdata,
  input  logic                 rf_ready,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [1:0] {StIdle, StWrite, StDone, StErr} state_e;

  state_e               state_q;
  logic                 sew_q, lmul_q;
  logic [4:0]           vd_q;
  logic [6:0]           vl_q;
  logic [31:0]          scalar_q;
  logic [1:0]           k_q;
  logic                 cmd_ready_q, rf_we_q, done_q, err_q;
  logic [4:0]           rf_waddr_q;
  logic [VLEN_BITS-1:0] rf_wdata_q;

  // Data for register k of the group; lanes at or beyond the clamped vl are zero.
  function automatic logic [VLEN_BITS-1:0] beat_data(input logic        sew_f,
                                                     input logic        lmul_f,
                                                     input logic [6:0]  vl_f,
                                                     input logic [31:0] sc,
                                                     input logic [1:0]  k);
    logic [6:0]           vmax;
    logic [6:0]           veff;
    logic [7:0]           idx;
    logic [VLEN_BITS-1:0] d;
    case ({sew_f, lmul_f})
      2'b00:   vmax = 7'd16;
      2'b10:   vmax = 7'd4;
      2'b01:   vmax = 7'd64;
      default: vmax = 7'd16;
    endcase
    veff = (vl_f < vmax) ? vl_f : vmax;
    d    = '0;
    for (int j = 0; j < 16; j++) begin
      idx = {2'b00, k, 4'b0000} + 8'(j);
      if (!sew_f && (idx < {1'b0, veff})) d[j*8 +: 8] = sc[7:0];
    end
    for (int j = 0; j < 4; j++) begin
      idx = {4'b0000, k, 2'b00} + 8'(j);
      if (sew_f && (idx < {1'b0, veff})) d[j*32 +: 32] = sc;
    end
    return d;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sew_q       <= 1'b0;
      lmul_q      <= 1'b0;
      vd_q        <= '0;
      vl_q        <= '0;
      scalar_q    <= '0;
      k_q         <= '0;
      cmd_ready_q <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            sew_q       <= sew;
            lmul_q      <= lmul;
            vd_q        <= vd_idx;
            vl_q        <= vl;
            scalar_q    <= scalar_in;
            k_q         <= 2'd0;
            cmd_ready_q <= 1'b0;
            // A 4-register group must start on an aligned register.
            if (lmul && (vd_idx[1:0] != 2'b00)) begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end else begin
              state_q    <= StWrite;
              rf_we_q    <= 1'b1;
              rf_waddr_q <= vd_idx;
              rf_wdata_q <= beat_data(sew, lmul, vl, scalar_in, 2'd0);
            end
          end
        end
        StWrite: begin
          if (rf_ready) begin
            if (k_q == (lmul_q ? 2'd3 : 2'd0)) begin
              state_q    <= StDone;
              rf_we_q    <= 1'b0;
              rf_waddr_q <= '0;
              rf_wdata_q <= '0;
              done_q     <= 1'b1;
            end else begin
              k_q        <= k_q + 2'd1;
              rf_waddr_q <= vd_q + 5'(k_q) + 5'd1;
              rf_wdata_q <= beat_data(sew_q, lmul_q, vl_q, scalar_q, k_q + 2'd1);
            end
          end
        end
        StDone, StErr: begin
          state_q     <= StIdle;
          cmd_ready_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_vsplat_wb_unit.sv
// Directed bench for vsplat_wb_unit: a byte-array group model feeds a beat scoreboard
// checked every cycle, plus per-command latency, handshake and reset checks.
`timescale 1ns/1ps
module tb_vsplat_wb_unit;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         sew;
  logic         lmul;
  logic [4:0]   vd_idx;
  logic [6:0]   vl;
  logic [31:0]  scalar_in;
  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [127:0] rf_wdata;
  logic         rf_ready;
  logic         done;
  logic         err;

  int checks   = 0;
  int failures = 0;

  logic [127:0] exp_d[$];
  logic [4:0]   exp_a[$];
  logic         hold_we = 1'b0;
  logic [4:0]   hold_a;
  logic [127:0] hold_d;

  vsplat_wb_unit #(.VLEN_BITS(128)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .sew       (sew),
    .lmul      (lmul),
    .vd_idx    (vd_idx),
    .vl        (vl),
    .scalar_in (scalar_in),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rf_ready  (rf_ready),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Whole group as a flat byte image: element e occupies bytes e*esz..e*esz+esz-1.
  function automatic logic [127:0] model_beat(input bit sew_m, input bit lmul_m, input int vl_m,
                                              input logic [31:0] sc, input int k);
    byte unsigned grp[64];
    int           esz;
    int           maxe;
    int           veff;
    logic [127:0] r;
    esz  = sew_m ? 4 : 1;
    maxe = (lmul_m ? 4 : 1) * 16 / esz;
    veff = (vl_m < maxe) ? vl_m : maxe;
    for (int b = 0; b < 64; b++) grp[b] = 8'h00;
    for (int e = 0; e < veff; e++)
      for (int i = 0; i < esz; i++) grp[e*esz + i] = sc[8*i +: 8];
    for (int j = 0; j < 16; j++) r[8*j +: 8] = grp[k*16 + j];
    return r;
  endfunction

  // Scoreboard: every write beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_we) begin
        check("stall_we_hold", rf_we, 1'b1);
        check("stall_addr_hold", rf_waddr, hold_a);
        check("stall_data_hold", rf_wdata, hold_d);
      end
      if (rf_we) begin
        if (exp_d.size() == 0) begin
          check("unexpected_write", rf_we, 1'b0);
        end else begin
          check("beat_addr", rf_waddr, exp_a[0]);
          check("beat_data", rf_wdata, exp_d[0]);
          if (rf_ready) begin
            void'(exp_d.pop_front());
            void'(exp_a.pop_front());
          end
        end
      end
      if (done) check("done_with_beats_left", exp_d.size(), 0);
      hold_we <= rf_we && !rf_ready;
      hold_a  <= rf_waddr;
      hold_d  <= rf_wdata;
    end else begin
      hold_we <= 1'b0;
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
    end
    if (!ok) check("cmd_ready_timeout", 1'b0, 1'b1);
  endtask

  task automatic issue(input bit sew_v, input bit lmul_v, input logic [4:0] vd_v, input int vl_v,
                       input logic [31:0] sc_v);
    sew       = sew_v;
    lmul      = lmul_v;
    vd_idx    = vd_v;
    vl        = 7'(vl_v);
    scalar_in = sc_v;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    // Scramble the command bus; the unit must use what it latched.
    sew       = ~sew_v;
    vd_idx    = ~vd_v;
    vl        = 7'h55;
    scalar_in = ~sc_v;
  endtask

  task automatic run_cmd(input string tag, input bit sew_v, input bit lmul_v,
                         input logic [4:0] vd_v, input int vl_v, input logic [31:0] sc_v,
                         input int stall_beat, input int stall_n, input int exp_end);
    bit ok;
    bit is_err;
    bit saw_err;
    int n;
    int beat;
    int stalls;
    int end_cyc;
    is_err = lmul_v && (vd_v[1:0] != 2'b00);
    wait_ready(ok);
    if (!ok) return;
    if (!is_err)
      for (int k = 0; k < (lmul_v ? 4 : 1); k++) begin
        exp_d.push_back(model_beat(sew_v, lmul_v, vl_v, sc_v, k));
        exp_a.push_back(5'(vd_v + 5'(k)));
      end
    issue(sew_v, lmul_v, vd_v, vl_v, sc_v);
    n = 1; beat = 0; stalls = 0; end_cyc = -1; ok = 1'b0; saw_err = 1'b0;
    while (!ok && n < 40) begin
      rf_ready = !(rf_we && beat == stall_beat && stalls < stall_n);
      if (!rf_ready) stalls++;
      @(negedge clk);
      check({tag, "_busy_cmd_ready"}, cmd_ready, 1'b0);
      if (done || err) begin
        ok      = 1'b1;
        end_cyc = n;
        saw_err = err;
      end else if (rf_we && rf_ready) begin
        beat++;
      end
      @(posedge clk);
      #1;
      n++;
    end
    rf_ready = 1'b1;
    if (!ok) check({tag, "_end_timeout"}, 1'b0, 1'b1);
    check({tag, "_end_cycle"}, end_cyc, exp_end);
    check({tag, "_err_flag"}, saw_err, is_err);
    check({tag, "_beats"}, beat, is_err ? 0 : (lmul_v ? 4 : 1));
    @(negedge clk);
    check({tag, "_ready_after"}, cmd_ready, 1'b1);
    check({tag, "_pulse_width"}, {done, err}, 2'b00);
  endtask

  initial begin
    bit ok;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    sew       = 1'b0;
    lmul      = 1'b0;
    vd_idx    = '0;
    vl        = '0;
    scalar_in = '0;
    rf_ready  = 1'b1;

    // Hand-computed pins on the model itself.
    check("model_a5", model_beat(0, 0, 16, 32'hA5, 0), {16{8'hA5}});
    check("model_dead_b2", model_beat(1, 1, 10, 32'hDEADBEEF, 2),
          {64'h0, 32'hDEADBEEF, 32'hDEADBEEF});
    check("model_dead_b3", model_beat(1, 1, 10, 32'hDEADBEEF, 3), 128'h0);
    check("model_7f_clamp", model_beat(0, 1, 100, 32'h7F, 3), {16{8'h7F}});
    check("model_vl5", model_beat(0, 0, 5, 32'h12345678, 0), {88'h0, {5{8'h78}}});

    #2;
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_rf_we", rf_we, 1'b0);
    check("rst_waddr", rf_waddr, 5'd0);
    check("rst_wdata", rf_wdata, 128'h0);
    check("rst_done_err", {done, err}, 2'b00);
    #20 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1'b1);

    run_cmd("a5", 0, 0, 5'd3, 16, 32'h000000A5, -1, 0, 2);
    run_cmd("deadbeef", 1, 1, 5'd8, 10, 32'hDEADBEEF, -1, 0, 5);
    run_cmd("stall7f", 0, 1, 5'd16, 100, 32'h0000007F, 1, 3, 8);
    run_cmd("misalign", 1, 1, 5'd5, 16, 32'h11111111, -1, 0, 1);
    run_cmd("vl0", 1, 0, 5'd31, 0, 32'hFFFFFFFF, -1, 0, 2);
    run_cmd("vl5", 0, 0, 5'd30, 5, 32'h12345678, -1, 0, 2);

    // Reset while beat 2 of a 4-register group is on the bus.
    wait_ready(ok);
    if (ok) begin
      for (int k = 0; k < 4; k++) begin
        exp_d.push_back(model_beat(1, 1, 16, 32'h0BADF00D, k));
        exp_a.push_back(5'(5'd12 + 5'(k)));
      end
      issue(1, 1, 5'd12, 16, 32'h0BADF00D);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("pre_rst_beat2_addr", rf_waddr, 5'd14);
      check("pre_rst_beat2_data", rf_wdata, {4{32'h0BADF00D}});
      #1 rst_n = 1'b0;
      #1;
      check("midrst_rf_we", rf_we, 1'b0);
      check("midrst_done", done, 1'b0);
      check("midrst_cmd_ready", cmd_ready, 1'b0);
      exp_d.delete();
      exp_a.delete();
      #14 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check("post_midrst_quiet", {rf_we, done, err}, 3'b000);
      end
      check("post_midrst_cmd_ready", cmd_ready, 1'b1);
    end

    run_cmd("recover", 1, 0, 5'd2, 4, 32'hCAFEF00D, -1, 0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vsplat_wb_unit.md
Name: vsplat_wb_unit

Overview:
- Multi-cycle vector scalar-broadcast unit; the write-side counterpart of the reduction path.
- Takes one scalar and a vector length, and builds a full vector register group: int8 or int32 elements, 1 or 4 registers.
- Writes the group into the vector register file one 128-bit register per beat over a valid/ready write port.
- Sits between the vector issue stage (command handshake) and the VRF write port.

Parameters:
- VLEN_BITS, 128, width of one vector register and of the write data bus; fixed at 128 for this revision.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  unit can accept a command (IDLE only)
- sew  input  1  0: int8 elements, 1: int32 elements
- lmul  input  1  0: 1 register, 1: 4-register group
- vd_idx  input  5  destination base register
- vl  input  7  active element count (0..127)
- scalar_in  input  32  broadcast value; int8 uses [7:0]
- rf_we  output  1  write beat valid
- rf_waddr  output  5  write register index
- rf_wdata  output  VLEN_BITS  write data
- rf_ready  input  1  VRF accepts beat
- done  output  1  one-cycle pulse, command complete
- err  output  1  one-cycle pulse, command rejected

Behaviour:
- Reset (async, rst_n=0): state=IDLE; cmd_ready=0 while rst_n=0, then 1 in IDLE; rf_we=0, rf_waddr=0, rf_wdata=0, done=0, err=0, beat counter=0.
- Reset mid-operation: pending beats discarded; no partial-beat completion after release.
- States:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch sew, lmul, vd_idx, vl, scalar_in.
  - If lmul=1 and vd_idx[1:0]!=0, go to ERR. Otherwise go to WRITE with beat counter k=0.
  - WRITE: rf_we=1, rf_waddr=vd_idx+k, rf_wdata=beat(k).
  - Outputs hold stable while rf_ready=0.
  - On rf_we&&rf_ready: k=k+1. After the last beat (k=0 for lmul=0, k=3 for lmul=1), go to DONE.
  - DONE: done=1 for one cycle, rf_we=0, then IDLE.
  - ERR: err=1 for one cycle, no writes, then IDLE.
- Command inputs are ignored outside IDLE; cmd_ready=0 in WRITE, DONE and ERR.
- Element limits:
  - Max elements: sew0/lmul0=16, sew1/lmul0=4, sew0/lmul1=64, sew1/lmul1=16.
  - Effective vl = min(vl, max).
- beat(k) content:
  - sew0: byte lane j (bits j*8+:8) = scalar[7:0] if (k*16+j) < vl_eff, else 8'h00.
  - sew1: lane j (bits j*32+:32) = scalar[31:0] if (k*4+j) < vl_eff, else 32'h0.
  - Tail policy is zero-fill.
- vl=0: all beats are still written, all-zero data.
- rf_waddr arithmetic is 5-bit. Alignment guarantees no wrap for lmul=1; for lmul=0 any vd_idx is legal.
- Latency with rf_ready held high, command accepted at edge 0:
  - First rf_we visible cycle 1.
  - lmul=0: done in cycle 2.
  - lmul=1: beats in cycles 1-4, done in cycle 5.
- Each rf_ready stall adds one cycle.
- Back-to-back: next command accepted in the cycle after done (IDLE).
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- sew=0, lmul=0, vd_idx=3, vl=16, scalar=0x000000A5, rf_ready=1 -> one beat, waddr=3, wdata={16{8'hA5}}, done in cycle 2.
- sew=1, lmul=1, vd_idx=8, vl=10, scalar=0xDEADBEEF -> 4 beats:
  - waddr 8, 9, 10, 11.
  - Beats 0-1 all 0xDEADBEEF.
  - Beat 2 lanes 0-1 DEADBEEF, lanes 2-3 zero.
  - Beat 3 zero.
  - done in cycle 5.
- sew=0, lmul=1, vl=100 (clamped to 64), scalar=0x7F, rf_ready low for 3 cycles during beat 1 -> beat 1 waddr/wdata held stable, 4 beats all {16{8'h7F}}, done in cycle 8.
- lmul=1, vd_idx=5 -> err pulse one cycle after accept, rf_we never asserted, cmd_ready high again in the following cycle.
- rst_n asserted during beat 2 of an lmul=1 command -> rf_we=0 and done=0 immediately; after release, IDLE with cmd_ready=1 and no further writes.
- vl=0, sew=1, lmul=0, vd_idx=31 -> one beat, waddr=31, wdata=0, done pulse.
